// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache and its icache follow-ons.
package dcache_pkg;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } dcache_state_t;

    // A binary tree over num_ways leaves has num_ways-1 internal nodes, one PLRU bit each.
    function automatic int plru_bits(input int num_ways);
        return num_ways - 1;
    endfunction

endpackage

// File: rtl/dcache_nway_plru_tree.sv
// Tree pseudo-LRU for one cache set. Bits are heap-ordered: node n (root = 1)
// lives in bit n-1, its children are nodes 2n and 2n+1. A bit of 0 points the
// victim search into the lower-numbered half of that subtree.
module plru_tree
    import dcache_pkg::*;
#(
    parameter int num_ways = 4,
    localparam int way_w   = $clog2(num_ways),
    localparam int plru_w  = plru_bits(num_ways)
) (
    input  logic [plru_w-1:0] bits_i,
    input  logic [way_w-1:0]  hit_way_i,
    output logic [plru_w-1:0] next_bits_o,
    output logic [way_w-1:0]  victim_o
);
    localparam int node_w = (plru_w > 1) ? $clog2(plru_w) : 1;

    int upd_node;
    int upd_dir;
    int vic_node;

    // Walk from the root along the hit way, turning every node on the path away from it
    always_comb begin
        next_bits_o = bits_i;
        upd_node    = 1;
        upd_dir     = 0;
        for (int l = 0; l < way_w; l++) begin
            upd_dir = (int'(hit_way_i) >> (way_w - 1 - l)) & 1;
            next_bits_o[node_w'(upd_node - 1)] = (upd_dir == 0);
            upd_node = 2 * upd_node + upd_dir;
        end
    end

    // Follow the bits from the root down to a leaf; the leaf number is the victim way
    always_comb begin
        vic_node = 1;
        for (int l = 0; l < way_w; l++) begin
            vic_node = 2 * vic_node + int'(bits_i[node_w'(vic_node - 1)]);
        end
        victim_o = way_w'(vic_node - num_ways);
    end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative, write-back, write-allocate L1 data cache with tree-PLRU
// replacement and invalid-way-first victim choice.
// Optional hit/miss counters are built when DCACHE_PERF_EN is defined.
module dcache_nway
    import dcache_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_index  = 4,
    parameter int num_ways = 4,
    localparam int s_tag   = 32 - s_offset - s_index,
    localparam int s_mask  = 2**s_offset,
    localparam int s_line  = 8 * s_mask
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [s_mask-1:0] mem_byte_enable,
    input  logic [s_line-1:0] mem_wdata,
    output logic [s_line-1:0] mem_rdata,
    output logic              mem_resp,
    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic [s_line-1:0] pmem_rdata,
    output logic [s_line-1:0] pmem_wdata,
    input  logic              pmem_resp,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
);
    localparam int num_sets = 2**s_index;
    localparam int way_w    = $clog2(num_ways);
    localparam int plru_w   = plru_bits(num_ways);

    logic [s_tag-1:0]    tag_arr_q  [num_sets][num_ways];
    logic [s_line-1:0]   data_arr_q [num_sets][num_ways];
    logic [num_ways-1:0] valid_q    [num_sets];
    logic [num_ways-1:0] dirty_q    [num_sets];
    logic [plru_w-1:0]   plru_q     [num_sets];

    dcache_state_t      state_q;
    logic [way_w-1:0]   victim_q;
    logic [s_tag-1:0]   miss_tag_q;
    logic [s_index-1:0] miss_idx_q;
    logic               pmem_read_q;
    logic               pmem_write_q;
    logic [31:0]        pmem_address_q;

    logic [s_tag-1:0]    req_tag;
    logic [s_index-1:0]  req_idx;
    logic                req;
    logic [num_ways-1:0] hit_vec;
    logic                hit;
    logic [way_w-1:0]    hit_way;
    logic                inv_found;
    logic [way_w-1:0]    inv_way;
    logic [way_w-1:0]    victim_sel;
    logic [way_w-1:0]    plru_victim;
    logic [plru_w-1:0]   plru_next;
    logic [s_line-1:0]   hit_line;
    logic [s_line-1:0]   merged_line;
    logic                unused_addr_bits;

    assign req_tag          = mem_address[31 -: s_tag];
    assign req_idx          = mem_address[s_offset +: s_index];
    assign unused_addr_bits = ^mem_address[s_offset-1:0];
    assign req              = mem_read | mem_write;

    for (genvar gi = 0; gi < num_ways; gi++) begin : g_way
        assign hit_vec[gi] = valid_q[req_idx][gi] && (tag_arr_q[req_idx][gi] == req_tag);
    end

    // Encode the (at most one) hitting way and the lowest-numbered invalid way
    always_comb begin
        hit       = |hit_vec;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (hit_vec[way_w'(w)]) hit_way = way_w'(w);
        end
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][way_w'(w)]) begin
                inv_found = 1'b1;
                inv_way   = way_w'(w);
            end
        end
    end

    plru_tree #(.num_ways(num_ways)) u_plru (
        .bits_i      (plru_q[req_idx]),
        .hit_way_i   (hit_way),
        .next_bits_o (plru_next),
        .victim_o    (plru_victim)
    );

    assign victim_sel = inv_found ? inv_way : plru_victim;
    assign hit_line   = data_arr_q[req_idx][hit_way];

    for (genvar gi = 0; gi < s_mask; gi++) begin : g_merge
        assign merged_line[8*gi +: 8] = mem_byte_enable[gi] ? mem_wdata[8*gi +: 8]
                                                            : hit_line[8*gi +: 8];
    end

    assign mem_resp     = (state_q == CHECK) && req && hit;
    assign mem_rdata    = hit_line;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    // Victim and set are latched at the miss, so the writeback line stays put even if the CPU misbehaves
    assign pmem_wdata   = data_arr_q[miss_idx_q][victim_q];

    // Miss-handling FSM plus the reset-cleared metadata (valid, dirty, PLRU)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CHECK;
            victim_q       <= '0;
            miss_tag_q     <= '0;
            miss_idx_q     <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            case (state_q)
                CHECK: begin
                    if (req && hit) begin
                        plru_q[req_idx] <= plru_next;
                        if (mem_write) dirty_q[req_idx][hit_way] <= 1'b1;
                    end else if (req) begin
                        victim_q   <= victim_sel;
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        if (dirty_q[req_idx][victim_sel]) begin
                            state_q        <= WRITEBACK;
                            pmem_write_q   <= 1'b1;
                            pmem_address_q <= {tag_arr_q[req_idx][victim_sel], req_idx, {s_offset{1'b0}}};
                        end else begin
                            state_q        <= ALLOCATE;
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= {req_tag, req_idx, {s_offset{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty_q[miss_idx_q][victim_q] <= 1'b0;
                        state_q        <= ALLOCATE;
                        pmem_write_q   <= 1'b0;
                        pmem_read_q    <= 1'b1;
                        pmem_address_q <= {miss_tag_q, miss_idx_q, {s_offset{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        valid_q[miss_idx_q][victim_q] <= 1'b1;
                        dirty_q[miss_idx_q][victim_q] <= 1'b0;
                        state_q     <= CHECK;
                        pmem_read_q <= 1'b0;
                    end
                end
                default: state_q <= CHECK;
            endcase
        end
    end

    // Tag and data arrays: write-merge on a write hit, whole-line fill on allocate completion
    always_ff @(posedge clk) begin
        if (!rst && (state_q == CHECK) && req && hit && mem_write) begin
            data_arr_q[req_idx][hit_way] <= merged_line;
        end else if (!rst && (state_q == ALLOCATE) && pmem_resp) begin
            data_arr_q[miss_idx_q][victim_q] <= pmem_rdata;
            tag_arr_q[miss_idx_q][victim_q]  <= miss_tag_q;
        end
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] perf_hits_q;
    logic [31:0] perf_misses_q;

    // Saturating hit/miss counters; a miss is counted once, as it leaves CHECK
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else if (state_q == CHECK && req) begin
            if (hit && perf_hits_q != '1)    perf_hits_q   <= perf_hits_q + 32'd1;
            if (!hit && perf_misses_q != '1) perf_misses_q <= perf_misses_q + 32'd1;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Self-checking bench for dcache_nway (default geometry: 4 ways, 16 sets, 32-byte lines).
// A behavioural cache model (line-address tags, per-set PLRU tree updated leaf-to-root)
// predicts every memory transaction, read data and counter value.
module tb_dcache_nway;
    localparam int WAYS  = 4;
    localparam int NSETS = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  mem_address = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_byte_enable = '0;
    logic [255:0] mem_wdata = '0;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_rdata = '0;
    logic [255:0] pmem_wdata;
    logic         pmem_resp = 1'b0;
    logic [31:0]  perf_hits;
    logic [31:0]  perf_misses;

    dcache_nway #(.s_offset(5), .s_index(4), .num_ways(WAYS)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_rdata      (pmem_rdata),
        .pmem_wdata      (pmem_wdata),
        .pmem_resp       (pmem_resp),
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [255:0] mem_model [int unsigned];
    bit           m_valid [NSETS][WAYS];
    bit           m_dirty [NSETS][WAYS];
    int unsigned  m_line  [NSETS][WAYS];
    logic [255:0] m_data  [NSETS][WAYS];
    int           m_tree  [NSETS][2*WAYS];
    int           m_hits;
    int           m_misses;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [255:0] mem_get(input int unsigned la);
        if (!mem_model.exists(la)) mem_model[la] = rand_line();
        return mem_model[la];
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        for (int s = 0; s < NSETS; s++)
            for (int n = 0; n < 2*WAYS; n++) m_tree[s][n] = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // Descend from the root: 0 = lower half, 1 = upper half
    function automatic int model_victim(input int s);
        int n = 1;
        while (n < WAYS) n = 2 * n + m_tree[s][n];
        return n - WAYS;
    endfunction

    // Climb from the touched leaf, making every ancestor point at the sibling subtree
    function automatic void model_touch(input int s, input int w);
        int n = w + WAYS;
        while (n > 1) begin
            m_tree[s][n / 2] = (n % 2 == 0) ? 1 : 0;
            n = n / 2;
        end
    endfunction

    // One CPU transaction: predict it with the model, then drive and serve the DUT
    task automatic access(input logic [31:0] addr, input bit wr, input logic [31:0] be,
                          input logic [255:0] wd, input string tag, output logic [255:0] rd);
        int           s, hw, v, nph, p, cyc, wait_cnt;
        bit           hit, active, done;
        int unsigned  la;
        int unsigned  exp_addr [2];
        bit           exp_wb [2];
        logic [255:0] exp_wd, exp_rd;

        la  = addr & 32'hFFFF_FFE0;
        s   = int'((addr >> 5) & 32'hF);
        hit = 1'b0;
        hw  = 0;
        nph = 0;
        exp_wd = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_line[s][w] == la) begin
                hit = 1'b1;
                hw  = w;
            end
        if (!hit) begin
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) v = model_victim(s);
            m_misses++;
            if (m_valid[s][v] && m_dirty[s][v]) begin
                exp_wb[0]   = 1'b1;
                exp_addr[0] = m_line[s][v];
                exp_wd      = m_data[s][v];
                mem_model[m_line[s][v]] = m_data[s][v];
                nph = 1;
            end
            exp_wb[nph]   = 1'b0;
            exp_addr[nph] = la;
            nph++;
            m_data[s][v]  = mem_get(la);
            m_line[s][v]  = la;
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            hw = v;
        end
        exp_rd = m_data[s][hw];
        if (wr) begin
            for (int i = 0; i < 32; i++) if (be[i]) m_data[s][hw][8*i +: 8] = wd[8*i +: 8];
            m_dirty[s][hw] = 1'b1;
        end
        model_touch(s, hw);
        m_hits++;

        @(negedge clk);
        mem_address     = addr;
        mem_write       = wr;
        mem_read        = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_byte_enable = be;
        mem_wdata       = wd;
        p = 0; active = 1'b0; done = 1'b0; cyc = 0; wait_cnt = 0;
        rd = '0;
        while (!done && cyc < 100) begin
            #1;
            if (mem_resp) begin
                done = 1'b1;
                rd   = mem_rdata;
                chk({tag, " phases"}, p, nph);
                if (!wr) chk({tag, " rdata"}, mem_rdata, exp_rd);
            end else if (pmem_read || pmem_write) begin
                if (!active) begin
                    active   = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                    if (p < nph) begin
                        chk({tag, " pmem_write"}, pmem_write, exp_wb[p]);
                        chk({tag, " pmem_addr"}, pmem_address, exp_addr[p]);
                        if (exp_wb[p]) chk({tag, " wb_data"}, pmem_wdata, exp_wd);
                    end else begin
                        chk({tag, " extra pmem phase"}, p, nph - 1);
                    end
                end
                if (wait_cnt == 0) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = (p < nph && !exp_wb[p]) ? mem_get(la) : rand_line();
                    active     = 1'b0;
                    p++;
                end else begin
                    wait_cnt--;
                end
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            cyc++;
        end
        chk({tag, " completed"}, done, 1'b1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        chk({tag, " single resp"}, mem_resp, 1'b0);
        $display("txn %s addr=%h wr=%0d hit=%0d phases=%0d", tag, addr, wr, hit, nph);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [255:0] rd, wd, a5;
        logic [31:0]  exp_h, exp_m, addr;
        int           cyc;

        model_reset();
        a5 = {32{8'hA5}};
        mem_model[32'h0000_1000] = a5;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset mem_resp", mem_resp, 1'b0);
        chk("reset pmem_read", pmem_read, 1'b0);
        chk("reset pmem_write", pmem_write, 1'b0);
        chk("reset pmem_address", pmem_address, 32'h0);
        chk("reset perf_hits", perf_hits, 32'h0);
        chk("reset perf_misses", perf_misses, 32'h0);

        // 1: cold read miss fills 0xA5 pattern
        access(32'h0000_1000, 1'b0, '0, '0, "t1 read", rd);
        chk("t1 rdata A5", rd, a5);

        // 2: partial write merges bytes 4..7
        wd = '0;
        wd[63:32] = 32'hDEAD_BEEF;
        access(32'h0000_1004, 1'b1, 32'h0000_00F0, wd, "t2 write", rd);
        access(32'h0000_1000, 1'b0, '0, '0, "t2 read", rd);
        chk("t2 merged word", rd[63:32], 32'hDEAD_BEEF);
        chk("t2 untouched word", rd[31:0], 32'hA5A5_A5A5);

        // 3: fill set 0, the fifth tag evicts the dirty PLRU way
        access(32'h0000_2000, 1'b0, '0, '0, "t3 fill2", rd);
        access(32'h0000_3000, 1'b0, '0, '0, "t3 fill3", rd);
        access(32'h0000_4000, 1'b0, '0, '0, "t3 fill4", rd);
        access(32'h0000_5000, 1'b0, '0, '0, "t3 evict", rd);

        // 4: write-hit ways 0,1,2 so every victim is dirty, then miss and observe the writeback
        access(32'h0000_5000, 1'b1, 32'hFFFF_FFFF, rand_line(), "t4 hit w0", rd);
        access(32'h0000_2000, 1'b1, 32'hFFFF_FFFF, rand_line(), "t4 hit w1", rd);
        access(32'h0000_3000, 1'b1, 32'hFFFF_FFFF, rand_line(), "t4 hit w2", rd);
        access(32'h0000_6000, 1'b0, '0, '0, "t4 plru miss", rd);
        access(32'h0000_4000, 1'b0, '0, '0, "t4 survivor", rd);

        // Randomised traffic over two sets and six tags
        for (int i = 0; i < 150; i++) begin
            addr = ((32'($urandom_range(0, 5)) + 32'd8) << 9)
                 | (($urandom_range(0, 1) != 0) ? 32'h60 : 32'hE0)
                 | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 1) != 0)
                access(addr, 1'b1, $urandom, rand_line(), "rnd write", rd);
            else
                access(addr, 1'b0, '0, '0, "rnd read", rd);
        end

        // 5: reset during ALLOCATE aborts the fill
        @(negedge clk);
        mem_address = 32'h0000_7040;
        mem_read    = 1'b1;
        cyc = 0;
        while (!pmem_read && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5 fill started", pmem_read, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t5 pmem_read dropped", pmem_read, 1'b0);
        chk("t5 no resp in reset", mem_resp, 1'b0);
        rst = 1'b0;
        mem_read = 1'b0;
        model_reset();
        access(32'h0000_7040, 1'b0, '0, '0, "t5 re-read", rd);

        // 6: counters after two misses and one hit, counted from a fresh reset
        pulse_reset();
        access(32'h0000_8000, 1'b0, '0, '0, "t6 miss A", rd);
        access(32'h0000_8020, 1'b0, '0, '0, "t6 miss B", rd);
        access(32'h0000_8000, 1'b0, '0, '0, "t6 hit A", rd);
`ifdef DCACHE_PERF_EN
        exp_h = 32'(m_hits);
        exp_m = 32'(m_misses);
`else
        exp_h = 32'h0;
        exp_m = 32'h0;
`endif
        chk("t6 perf_hits", perf_hits, exp_h);
        chk("t6 perf_misses", perf_misses, exp_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
